wb_addr_router: RTL and testbench
=================================

WB_ADDR_ROUTER -- requirements
Module: wb_addr_router

Interface
REQ-001 SHALL have parameter NUM_SLV, default 3, meaning number of slave channels (1..8).
REQ-002 SHALL have parameter BASE_ADDR, default {32'h0200_0800, 32'h0200_0100, 32'h0200_0000}, meaning packed NUM_SLV*32 base addresses; slave k is at bits [32k+31:32k].
REQ-003 SHALL have parameter ADDR_MASK, default {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFC0}, meaning packed per-slave compare masks.
REQ-004 SHALL have parameter TIMEOUT, default 16, meaning the maximum number of BUSY cycles to wait for a slave ACK (2..255).
REQ-005 SHALL have port iCLK, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port iRST, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port iADR, input, 32 bits: master address.
REQ-008 SHALL have port iSTB, input, 1 bit: master strobe, active high.
REQ-009 SHALL have port oACK, input-side response, output, 1 bit: one-cycle transfer-complete pulse.
REQ-010 SHALL have port oERR, output, 1 bit: one-cycle pulse for an unmapped address or a timeout.
REQ-011 SHALL have port oDAT, output, 32 bits: registered read data.
REQ-012 SHALL have port oSTB_S, output, NUM_SLV bits: one-hot slave strobes.
REQ-013 SHALL have port iACK_S, input, NUM_SLV bits: slave acknowledges.
REQ-014 SHALL have port iDAT_S, input, NUM_SLV*32 bits: packed slave read data.
REQ-015 SHALL have port oERR_CNT, output, 8 bits: saturating count of oERR pulses.

Function
REQ-016 Slave k SHALL hit when (iADR & ADDR_MASK[k]) == (BASE_ADDR[k] & ADDR_MASK[k]); on multiple hits the lowest index SHALL win.
REQ-017 FSM states SHALL be IDLE, BUSY and RESP.
REQ-018 In IDLE with iSTB=1 and a hit, the block SHALL latch one-hot sel, go to BUSY, and assert oSTB_S[sel] from the next cycle (1-cycle decode latency).
REQ-019 In IDLE with iSTB=1 and no hit, the block SHALL go to RESP with oERR=1 in the next cycle, and no oSTB_S bit SHALL assert.
REQ-020 In BUSY, oSTB_S SHALL equal sel & {NUM_SLV{iSTB}}, and iACK_S bits outside sel SHALL be ignored.
REQ-021 In BUSY with iACK_S[sel]=1, the block SHALL capture iDAT_S[sel] into oDAT and go to RESP with oACK=1 in the next cycle.
REQ-022 BUSY SHALL count cycles from 0; when the count reaches TIMEOUT-1 with no ACK, the block SHALL go to RESP with oERR=1.
REQ-023 An ACK arriving in the same cycle as the timeout condition SHALL win: oACK, not oERR.
REQ-024 iSTB=0 in BUSY SHALL abort to IDLE with neither oACK nor oERR, and the counter SHALL clear.
REQ-025 RESP SHALL last exactly one cycle and then return to IDLE; oACK and oERR SHALL never be 1 together.
REQ-026 iSTB still high in the IDLE that follows RESP SHALL start a new transaction (back-to-back issue allowed).
REQ-027 oDAT SHALL hold its value until the next captured ACK.
REQ-028 oERR_CNT SHALL increment on each oERR pulse and saturate at 8'hFF.

Reset
REQ-029 Asserting iRST SHALL immediately force: state IDLE, sel 0, counter 0, oSTB_S 0, oACK 0, oERR 0, oDAT 32'h0, oERR_CNT 8'h0.
REQ-030 Reset asserted mid-transaction SHALL drop oSTB_S asynchronously and generate no response pulse.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the bus width constant (32), and the default base/mask constants.
REQ-032 One sub-module, wb_addr_match (combinational hit/priority one-hot encoder), SHALL be instantiated.

Verification
REQ-033 Directed test: iADR=0x0200_0104, iSTB=1; slave1 ACKs 3 cycles later with 0xDEAD_BEEF -> oSTB_S=3'b010 from cycle 1, then oACK pulse with oDAT=0xDEAD_BEEF.
REQ-034 Directed test: iADR=0x0200_003C -> oSTB_S=3'b001; iADR=0x0200_0040 -> oERR pulse 1 cycle later, oSTB_S stays 0, oERR_CNT=1.
REQ-035 Directed test: iADR=0x0200_0808 with no slave ACK -> oSTB_S=3'b100 for 16 cycles, then oERR pulse, then IDLE.
REQ-036 Directed test: slave ACK in the 16th BUSY cycle -> oACK=1, oERR=0, oERR_CNT unchanged.
REQ-037 Directed test: iSTB dropped in BUSY cycle 2 -> IDLE with no pulse; iRST mid-BUSY -> all outputs 0 immediately.
REQ-038 Directed test: 300 unmapped accesses -> oERR_CNT=8'hFF.

Source files
------------

// File: rtl/wb_addr_router_pkg.sv
// Shared constants and types for the Wishbone address router.
// Latency: n/a (package only).
// Backpressure: n/a.
package wb_addr_router_pkg;

    localparam int BUS_W       = 32;
    localparam int DEF_NUM_SLV = 3;

    // Default map: slave0 is a 64-byte window, slaves 1 and 2 are 16-byte windows.
    localparam logic [DEF_NUM_SLV*BUS_W-1:0] DEF_BASE_ADDR =
        {32'h0200_0800, 32'h0200_0100, 32'h0200_0000};
    localparam logic [DEF_NUM_SLV*BUS_W-1:0] DEF_ADDR_MASK =
        {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFC0};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/wb_addr_match.sv
// Address decoder: masked compare per slave, lowest index wins on overlap.
// Latency: purely combinational.
// Backpressure: none.
// Ports: adr (master address in), hit_oh (one-hot winning slave), hit (any slave matched).
module wb_addr_match
    import wb_addr_router_pkg::*;
#(
    parameter int                         NUM_SLV   = DEF_NUM_SLV,
    parameter logic [NUM_SLV*BUS_W-1:0]   BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [NUM_SLV*BUS_W-1:0]   ADDR_MASK = DEF_ADDR_MASK
)(
    input  logic [BUS_W-1:0]   adr,
    output logic [NUM_SLV-1:0] hit_oh,
    output logic               hit
);

    // Walk from the top index down so a lower-index match overwrites any
    // higher one; the result stays one-hot.
    always_comb begin
        hit_oh = '0;
        for (int k = NUM_SLV - 1; k >= 0; k--) begin
            if ((adr & ADDR_MASK[k*BUS_W +: BUS_W]) ==
                (BASE_ADDR[k*BUS_W +: BUS_W] & ADDR_MASK[k*BUS_W +: BUS_W])) begin
                hit_oh    = '0;
                hit_oh[k] = 1'b1;
            end
        end
    end

    assign hit = |hit_oh;

endmodule

// File: rtl/wb_addr_router.sv
// Wishbone single-master to NUM_SLV-slave address router with ACK timeout and error counter.
// Latency: 1 cycle decode to slave strobe; response pulse 1 cycle after slave ACK/timeout/miss.
// Backpressure: master holds iSTB until oACK/oERR; dropping iSTB mid-transfer aborts silently.
// Ports: iCLK/iRST clock and async reset; iADR/iSTB master request; oACK/oERR/oDAT master response;
//        oSTB_S/iACK_S/iDAT_S slave side; oERR_CNT saturating error-pulse count.
module wb_addr_router
    import wb_addr_router_pkg::*;
#(
    parameter int                         NUM_SLV   = DEF_NUM_SLV,
    parameter logic [NUM_SLV*BUS_W-1:0]   BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [NUM_SLV*BUS_W-1:0]   ADDR_MASK = DEF_ADDR_MASK,
    parameter int                         TIMEOUT   = 16
)(
    input  logic                       iCLK,
    input  logic                       iRST,
    input  logic [BUS_W-1:0]           iADR,
    input  logic                       iSTB,
    output logic                       oACK,
    output logic                       oERR,
    output logic [BUS_W-1:0]           oDAT,
    output logic [NUM_SLV-1:0]         oSTB_S,
    input  logic [NUM_SLV-1:0]         iACK_S,
    input  logic [NUM_SLV*BUS_W-1:0]   iDAT_S,
    output logic [7:0]                 oERR_CNT
);

    state_t               state_q, state_d;
    logic [NUM_SLV-1:0]   sel_q, sel_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 ack_q, ack_d;
    logic                 err_q, err_d;
    logic [BUS_W-1:0]     dat_q, dat_d;
    logic [7:0]           err_cnt_q, err_cnt_d;

    logic [NUM_SLV-1:0]   hit_oh;
    logic                 hit;
    logic                 slv_ack;
    logic                 tmo;
    logic [BUS_W-1:0]     dat_mux;

    wb_addr_match #(
        .NUM_SLV   (NUM_SLV),
        .BASE_ADDR (BASE_ADDR),
        .ADDR_MASK (ADDR_MASK)
    ) u_match (
        .adr    (iADR),
        .hit_oh (hit_oh),
        .hit    (hit)
    );

    // Only the selected slave's ACK counts; the rest are ignored.
    assign slv_ack = |(iACK_S & sel_q);
    assign tmo     = (cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        dat_mux = '0;
        for (int k = 0; k < NUM_SLV; k++) begin
            if (sel_q[k]) begin
                dat_mux = iDAT_S[k*BUS_W +: BUS_W];
            end
        end
    end

    // State register (plus datapath flops).
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            sel_q     <= '0;
            cnt_q     <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            dat_q     <= '0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            dat_q     <= dat_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (iSTB)      state_d = hit ? ST_BUSY : ST_RESP;
            ST_BUSY: if (!iSTB)     state_d = ST_IDLE;
                     else if (slv_ack || tmo) state_d = ST_RESP;
            ST_RESP:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Datapath next values. The counter defaults to zero so any exit from
    // BUSY (response or abort) leaves it cleared for the next transfer.
    always_comb begin
        sel_d     = sel_q;
        cnt_d     = '0;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        dat_d     = dat_q;
        err_cnt_d = err_cnt_q;
        if (state_q == ST_IDLE && iSTB) begin
            if (hit) sel_d = hit_oh;
            else     err_d = 1'b1;
        end else if (state_q == ST_BUSY && iSTB) begin
            // ACK is tested before timeout so a last-cycle ACK wins.
            if (slv_ack) begin
                ack_d = 1'b1;
                dat_d = dat_mux;
            end else if (tmo) begin
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
        if (err_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Outputs. Strobes decode from state_q so an async reset drops them at once.
    always_comb begin
        oSTB_S   = (state_q == ST_BUSY) ? (sel_q & {NUM_SLV{iSTB}}) : '0;
        oACK     = ack_q;
        oERR     = err_q;
        oDAT     = dat_q;
        oERR_CNT = err_cnt_q;
    end

endmodule

// File: tb/tb_wb_addr_router.sv
`timescale 1ns/1ps
module tb_wb_addr_router;

    localparam int TMO = 16;

    logic         iCLK = 1'b0;
    logic         iRST;
    logic [31:0]  iADR;
    logic         iSTB;
    logic         oACK;
    logic         oERR;
    logic [31:0]  oDAT;
    logic [2:0]   oSTB_S;
    logic [2:0]   iACK_S;
    logic [95:0]  iDAT_S;
    logic [7:0]   oERR_CNT;

    int vectors    = 0;
    int miscompares = 0;

    // Reference state: last acknowledged data and total error pulses.
    logic [31:0] ref_dat  = 32'h0;
    int          ref_errs = 0;

    always #5 iCLK = ~iCLK;

    wb_addr_router #(
        .NUM_SLV (3),
        .TIMEOUT (TMO)
    ) dut (
        .iCLK     (iCLK),
        .iRST     (iRST),
        .iADR     (iADR),
        .iSTB     (iSTB),
        .oACK     (oACK),
        .oERR     (oERR),
        .oDAT     (oDAT),
        .oSTB_S   (oSTB_S),
        .iACK_S   (iACK_S),
        .iDAT_S   (iDAT_S),
        .oERR_CNT (oERR_CNT)
    );

    typedef struct {
        logic [31:0] adr;
        int          ack_cyc;   // BUSY cycle index in which the slave ACKs; >= TMO means never
        logic [31:0] dat;
        bit          noise;     // random ACKs on non-selected slaves
        logic [2:0]  e_stb;
        int          e_busy;
        bit          e_ack;
        bit          e_err;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Address map straight from the rules: masked compare, lowest index first.
    function automatic logic [2:0] ref_decode(input logic [31:0] a);
        logic [31:0] b [3];
        logic [31:0] m [3];
        logic [2:0]  r;
        b[0] = 32'h0200_0000; m[0] = 32'hFFFF_FFC0;
        b[1] = 32'h0200_0100; m[1] = 32'hFFFF_FFF0;
        b[2] = 32'h0200_0800; m[2] = 32'hFFFF_FFF0;
        r = 3'b000;
        for (int k = 0; k < 3; k++) begin
            if (r == 3'b000 && (a & m[k]) == (b[k] & m[k])) r[k] = 1'b1;
        end
        return r;
    endfunction

    // Transaction-level expectation.
    task automatic model_txn(input logic [31:0] adr, input int ack_cyc,
                             output logic [2:0] e_stb, output int e_busy,
                             output bit e_ack, output bit e_err);
        e_stb = ref_decode(adr);
        if (e_stb == 3'b000) begin
            e_busy = 0; e_ack = 1'b0; e_err = 1'b1;
        end else if (ack_cyc < TMO) begin
            e_busy = ack_cyc + 1; e_ack = 1'b1; e_err = 1'b0;
        end else begin
            e_busy = TMO; e_ack = 1'b0; e_err = 1'b1;
        end
    endtask

    // Drive one held-strobe transfer and observe what the router does.
    task automatic run_txn(input logic [31:0] adr, input int ack_cyc, input logic [31:0] dat,
                           input bit noise,
                           output logic [2:0] stb_seen, output int busy, output int lat,
                           output bit got_ack, output bit got_err,
                           output logic [31:0] dat_p, output logic [7:0] errcnt);
        logic [2:0] tgt;
        bit         done;
        tgt      = ref_decode(adr);
        stb_seen = 3'b000; busy = 0; lat = -1;
        got_ack  = 1'b0; got_err = 1'b0; dat_p = 32'h0; errcnt = 8'h0; done = 1'b0;
        @(negedge iCLK);
        iADR   = adr;
        iSTB   = 1'b1;
        iACK_S = 3'b000;
        iDAT_S = {$urandom, $urandom, $urandom};
        for (int k = 0; k < 3; k++) begin
            if (tgt[k]) iDAT_S[k*32 +: 32] = dat;
        end
        for (int c = 0; c < TMO + 8 && !done; c++) begin
            @(negedge iCLK);
            if (oACK || oERR) begin
                if (lat < 0) lat = c;
                got_ack = oACK; got_err = oERR; dat_p = oDAT; done = 1'b1;
                chk("resp_no_strobe", 32'(oSTB_S), 32'h0);
                iSTB   = 1'b0;
                iACK_S = 3'b000;
            end else begin
                if (oSTB_S != 3'b000) begin
                    if (lat < 0) lat = c;
                    stb_seen = stb_seen | oSTB_S;
                    busy++;
                end
                iACK_S = noise ? (3'($urandom) & ~tgt) : 3'b000;
                if (oSTB_S != 3'b000 && busy - 1 == ack_cyc) iACK_S = iACK_S | tgt;
            end
        end
        if (!done) begin
            chk("txn_cycle_budget", 32'd0, 32'd1);
            iSTB   = 1'b0;
            iACK_S = 3'b000;
        end
        @(negedge iCLK);
        chk("pulse_one_cycle", 32'({oACK, oERR}), 32'h0);
        errcnt = oERR_CNT;
    endtask

    task automatic do_and_check(input logic [31:0] adr, input int ack_cyc, input logic [31:0] dat,
                                input bit noise, input logic [2:0] e_stb, input int e_busy,
                                input bit e_ack, input bit e_err);
        logic [2:0]  stb;
        int          busy, lat;
        bit          ga, ge;
        logic [31:0] dp;
        logic [7:0]  ec;
        run_txn(adr, ack_cyc, dat, noise, stb, busy, lat, ga, ge, dp, ec);
        if (e_ack) ref_dat = dat;
        if (e_err) ref_errs++;
        chk("strobe_select", 32'(stb), 32'(e_stb));
        chk("busy_cycles", 32'(busy), 32'(e_busy));
        chk("first_event_latency", 32'(lat), 32'd0);
        chk("ack_pulse", 32'(ga), 32'(e_ack));
        chk("err_pulse", 32'(ge), 32'(e_err));
        chk("read_data", dp, ref_dat);
        chk("err_count", 32'(ec), (ref_errs > 255) ? 32'd255 : 32'(ref_errs));
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]  e_stb;
        int          e_busy;
        bit          e_ack, e_err;
        logic [31:0] a;
        int          ac;

        tbl[0] = '{32'h0200_0104,  2, 32'hDEAD_BEEF, 1'b0, 3'b010,   3, 1'b1, 1'b0};
        tbl[1] = '{32'h0200_003C,  0, 32'h1111_2222, 1'b1, 3'b001,   1, 1'b1, 1'b0};
        tbl[2] = '{32'h0200_0040,  0, 32'h3333_4444, 1'b0, 3'b000,   0, 1'b0, 1'b1};
        tbl[3] = '{32'h0200_0808, 99, 32'h5555_6666, 1'b0, 3'b100,  16, 1'b0, 1'b1};
        tbl[4] = '{32'h0200_0808, 15, 32'hCAFE_F00D, 1'b1, 3'b100,  16, 1'b1, 1'b0};
        tbl[5] = '{32'h0200_080F, 16, 32'h7777_8888, 1'b0, 3'b100,  16, 1'b0, 1'b1};
        tbl[6] = '{32'h0200_0000,  5, 32'h0BAD_F00D, 1'b0, 3'b001,   6, 1'b1, 1'b0};
        tbl[7] = '{32'h0200_010F,  0, 32'h1234_ABCD, 1'b1, 3'b010,   1, 1'b1, 1'b0};
        tbl[8] = '{32'h0200_0110,  0, 32'h9999_AAAA, 1'b0, 3'b000,   0, 1'b0, 1'b1};
        tbl[9] = '{32'h0300_0000,  0, 32'hBBBB_CCCC, 1'b0, 3'b000,   0, 1'b0, 1'b1};

        iRST = 1'b1; iADR = 32'h0; iSTB = 1'b0; iACK_S = 3'b000; iDAT_S = '0;
        repeat (3) @(negedge iCLK);
        chk("reset_outputs", 32'({oSTB_S, oACK, oERR}), 32'h0);
        chk("reset_dat", oDAT, 32'h0);
        chk("reset_err_cnt", 32'(oERR_CNT), 32'h0);
        iRST = 1'b0;
        @(negedge iCLK);
        chk("idle_outputs", 32'({oSTB_S, oACK, oERR}), 32'h0);

        // Directed table.
        for (int i = 0; i < 10; i++) begin
            do_and_check(tbl[i].adr, tbl[i].ack_cyc, tbl[i].dat, tbl[i].noise,
                         tbl[i].e_stb, tbl[i].e_busy, tbl[i].e_ack, tbl[i].e_err);
        end

        // Randomized transfers against the transaction model.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: a = 32'h0200_0000 + 32'($urandom_range(0, 127));
                1: a = 32'h0200_0100 + 32'($urandom_range(0, 31));
                2: a = 32'h0200_0800 + 32'($urandom_range(0, 31));
                default: a = $urandom;
            endcase
            ac = $urandom_range(0, 20);
            model_txn(a, ac, e_stb, e_busy, e_ack, e_err);
            do_and_check(a, ac, $urandom, 1'($urandom), e_stb, e_busy, e_ack, e_err);
        end

        // Back-to-back: iSTB held through RESP starts the next transfer.
        @(negedge iCLK);
        iADR = 32'h0200_0000; iSTB = 1'b1; iACK_S = 3'b000;
        iDAT_S[31:0] = 32'h1234_5678;
        @(negedge iCLK);
        chk("b2b_strobe0", 32'(oSTB_S), 32'h1);
        iACK_S = 3'b001;
        @(negedge iCLK);
        chk("b2b_ack0", 32'({oACK, oERR}), 32'h2);
        chk("b2b_dat0", oDAT, 32'h1234_5678);
        iACK_S = 3'b000; iADR = 32'h0200_0104; iDAT_S[63:32] = 32'hA5A5_0001;
        @(negedge iCLK);
        chk("b2b_idle_gap", 32'({oSTB_S, oACK, oERR}), 32'h0);
        @(negedge iCLK);
        chk("b2b_strobe1", 32'(oSTB_S), 32'h2);
        iACK_S = 3'b010;
        @(negedge iCLK);
        chk("b2b_ack1", 32'({oACK, oERR}), 32'h2);
        chk("b2b_dat1", oDAT, 32'hA5A5_0001);
        ref_dat = 32'hA5A5_0001;
        iSTB = 1'b0; iACK_S = 3'b000;
        @(negedge iCLK);

        // Abort: strobe dropped in BUSY cycle 2.
        @(negedge iCLK);
        iADR = 32'h0200_0808; iSTB = 1'b1; iACK_S = 3'b000;
        @(negedge iCLK);
        chk("abort_strobe_c1", 32'(oSTB_S), 32'h4);
        @(negedge iCLK);
        chk("abort_strobe_c2", 32'(oSTB_S), 32'h4);
        iSTB = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            chk("abort_quiet", 32'({oSTB_S, oACK, oERR}), 32'h0);
        end
        // A full timeout afterwards proves the BUSY counter restarted from zero.
        do_and_check(32'h0200_0808, 99, 32'h0, 1'b0, 3'b100, TMO, 1'b0, 1'b1);

        // Saturation of the error counter.
        for (int i = 0; i < 300; i++) begin
            do_and_check(32'h0400_0000 + 32'(i), 0, 32'h0, 1'b0, 3'b000, 0, 1'b0, 1'b1);
        end
        chk("err_cnt_saturated", 32'(oERR_CNT), 32'hFF);

        // Reset in the middle of BUSY.
        @(negedge iCLK);
        iADR = 32'h0200_0104; iSTB = 1'b1; iACK_S = 3'b000;
        @(negedge iCLK);
        chk("pre_reset_strobe", 32'(oSTB_S), 32'h2);
        #2 iRST = 1'b1; iACK_S = 3'b010;
        #1;
        chk("rst_async_strobe", 32'(oSTB_S), 32'h0);
        chk("rst_async_pulses", 32'({oACK, oERR}), 32'h0);
        chk("rst_async_dat", oDAT, 32'h0);
        chk("rst_async_err_cnt", 32'(oERR_CNT), 32'h0);
        @(negedge iCLK);
        iSTB = 1'b0; iACK_S = 3'b000;
        @(negedge iCLK);
        iRST = 1'b0;
        ref_dat = 32'h0; ref_errs = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge iCLK);
            chk("post_reset_quiet", 32'({oSTB_S, oACK, oERR}), 32'h0);
        end
        do_and_check(32'h0200_0040, 0, 32'h0, 1'b0, 3'b000, 0, 1'b0, 1'b1);
        do_and_check(32'h0200_0100, 1, 32'h600D_D00D, 1'b1, 3'b010, 2, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
